alu_acc_sequencer: RTL
======================

Name: alu_acc_sequencer

Overview:
- Sequential front-end for the 4-bit combinational ALU.
- Owns the two accumulators (AccA, AccB) and the carry flag, and accepts a stream of commands over a valid/ready handshake.
- Drives the ALU operand and opcode pins, waits a settle window, then writes the ALU result back into AccA.
- Returns one response per command to the downstream consumer.

Parameters:
- WIDTH, 4: accumulator/ALU width. Fixed to 4 to match the ALU; other values are unsupported.
- SETTLE_CYCLES, 1: cycles the ALU inputs are held stable before capture. Range 1..7.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_code  in  2  00 LDA, 01 LDB, 10 EXEC, 11 MOVB
- cmd_data  in  WIDTH  immediate for LDA/LDB; ignored otherwise
- cmd_op  in  3  ALU opcode {op0,op1,op2} for EXEC; ignored otherwise
- alu_x  out  WIDTH  to ALU x0..x3 (alu_x[3]=x0 MSB … alu_x[0]=x3)
- alu_y  out  WIDTH  to ALU y0..y3, same mapping
- alu_op  out  3  to ALU op0,op1,op2 (alu_op[2]=op0)
- alu_out  in  WIDTH  from ALU out0..out3, same mapping
- alu_carry  in  1  from ALU carry
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  WIDTH  AccA after the command
- rsp_carry  out  1  carry flag after the command
- acc_a, acc_b  out  WIDTH  live accumulator values (debug)

Behaviour:
- Reset (async, rst_n=0): all outputs and registers go to 0. This covers acc_a, acc_b, carry flag, alu_op, rsp_valid, rsp_data, rsp_carry and the settle counter. State goes to IDLE. Reset asserted mid-command aborts it; no response is produced.
- alu_x mirrors acc_a and alu_y mirrors acc_b at all times.
- Opcode map, {op0,op1,op2}:
  - 000 AND, 001 NOT, 010 OR, 011 XOR
  - 100 SHL, 101 ADD, 110 SUB, 111 TWOS
- FSM states: IDLE, SETTLE, CAPTURE, RESP.
- IDLE: cmd_ready=1. Handshake completes when cmd_valid&&cmd_ready.
  - LDA: acc_a<=cmd_data → RESP.
  - LDB: acc_b<=cmd_data → RESP.
  - MOVB: acc_b<=acc_a → RESP.
  - EXEC: alu_op<=cmd_op; counter<=SETTLE_CYCLES-1 → SETTLE.
- SETTLE: cmd_ready=0. Counter decrements each cycle; at 0 → CAPTURE.
  - Operands and alu_op are stable throughout.
- CAPTURE: one cycle. acc_a<=alu_out, carry<=alu_carry → RESP.
  - acc_b is unchanged.
- RESP: rsp_valid=1, rsp_data=acc_a, rsp_carry=carry.
  - Values are stable while rsp_ready=0.
  - rsp_valid&&rsp_ready → IDLE next cycle.
- Carry flag is written only by EXEC. LDA, LDB and MOVB preserve it.
- alu_op holds its last EXEC value outside EXEC.
- Latency, command accept to rsp_valid:
  - loads and MOVB: 1 cycle
  - EXEC: SETTLE_CYCLES+2 cycles
- Throughput: one command per (latency+1) cycles with rsp_ready held high. cmd_ready is 0 in every state except IDLE, so there is no command overlap.
- cmd_valid asserted while cmd_ready=0 is held off; the command is neither consumed nor lost.
- Wrap-around and overflow are the ALU's concern. The block stores exactly WIDTH bits of alu_out plus alu_carry.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_AND … OP_TWOS)
  - command codes (CMD_LDA, CMD_LDB, CMD_EXEC, CMD_MOVB)
  - state enum encoding
  - ALU_WIDTH=4
- No sub-module. The settle counter and FSM are inline; the ALU is instantiated by the parent, not inside this block.

Test Plan:
1. Reset mid-EXEC: issue EXEC ADD, assert rst_n=0 in SETTLE → all outputs 0, state IDLE, no rsp_valid after release.
2. LDA 0111, LDB 1110, EXEC ADD (101) → rsp_data=0101, rsp_carry=1, rsp_valid exactly SETTLE_CYCLES+2 cycles after EXEC accept.
3. LDA 0111, LDB 1110, EXEC AND (000) → rsp_data=0110, and alu_op=000 held stable through SETTLE.
4. Backpressure: hold rsp_ready=0 for 5 cycles after a LDA 1010 → rsp_valid, rsp_data=1010 stable; cmd_ready=0; a pending cmd_valid is not consumed until 1 cycle after the response handshake.
5. Carry persistence: after a test-2 EXEC (carry=1), issue LDB 0011 then MOVB → carry stays 1; acc_b=0101; rsp_data=0101.
6. Parameter sweep SETTLE_CYCLES=3: EXEC XOR with 1100/1010 → rsp_data=0110, latency 5 cycles; ALU-side model changes during SETTLE are not captured early.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU accumulator sequencer: widths, opcodes,
// command codes and FSM state encoding.
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  // ALU opcodes as {op0,op1,op2}
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_NOT  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_ADD  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_TWOS = 3'b111;

  localparam logic [1:0] CMD_LDA  = 2'b00;
  localparam logic [1:0] CMD_LDB  = 2'b01;
  localparam logic [1:0] CMD_EXEC = 2'b10;
  localparam logic [1:0] CMD_MOVB = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

endpackage

// File: rtl/alu_acc_sequencer.sv
// Sequential front-end for the external 4-bit ALU: owns AccA/AccB and the
// carry flag, runs one command at a time and returns one response each.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | cmd_ready=1, waiting for a command handshake
// ST_SETTLE  | ALU operands/opcode held stable, settle counter running
// ST_CAPTURE | one cycle, ALU result and carry written into AccA/carry
// ST_RESP    | rsp_valid=1 until the consumer takes the response
module alu_acc_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH         = ALU_WIDTH,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_code,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [2:0]       cmd_op,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic [WIDTH-1:0] acc_a,
  output logic [WIDTH-1:0] acc_b
);

  localparam logic [2:0] CNT_LOAD = 3'(SETTLE_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc_a;
  logic [WIDTH-1:0] r_acc_b;
  logic             r_carry;
  logic [2:0]       r_alu_op;
  logic [2:0]       r_cnt;

  logic w_ld_a;
  logic w_ld_b;
  logic w_mov_b;
  logic w_exec;
  logic w_cap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    w_ld_a      = 1'b0;
    w_ld_b      = 1'b0;
    w_mov_b     = 1'b0;
    w_exec      = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_code)
            CMD_LDA: begin
              w_ld_a      = 1'b1;
              w_state_nxt = ST_RESP;
            end
            CMD_LDB: begin
              w_ld_b      = 1'b1;
              w_state_nxt = ST_RESP;
            end
            CMD_MOVB: begin
              w_mov_b     = 1'b1;
              w_state_nxt = ST_RESP;
            end
            default: begin
              w_exec      = 1'b1;
              w_state_nxt = ST_SETTLE;
            end
          endcase
        end
      end
      ST_SETTLE: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_cap       = 1'b1;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_a  <= '0;
      r_acc_b  <= '0;
      r_carry  <= 1'b0;
      r_alu_op <= 3'd0;
      r_cnt    <= 3'd0;
    end else begin
      if (w_ld_a) begin
        r_acc_a <= cmd_data;
      end else if (w_cap) begin
        r_acc_a <= alu_out;
      end
      // carry is only ever written by an EXEC capture
      if (w_cap) begin
        r_carry <= alu_carry;
      end
      if (w_ld_b) begin
        r_acc_b <= cmd_data;
      end else if (w_mov_b) begin
        r_acc_b <= r_acc_a;
      end
      if (w_exec) begin
        r_alu_op <= cmd_op;
        r_cnt    <= CNT_LOAD;
      end else if (r_state == ST_SETTLE && r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  // Accumulators feed the ALU directly; the response is the live AccA/carry,
  // which cannot change while a response is pending.
  assign alu_x     = r_acc_a;
  assign alu_y     = r_acc_b;
  assign alu_op    = r_alu_op;
  assign acc_a     = r_acc_a;
  assign acc_b     = r_acc_b;
  assign rsp_data  = r_acc_a;
  assign rsp_carry = r_carry;

endmodule
